regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between NUM_REQ requesters (writeback stage, multiply/divide unit completion, exception/status writer, etc.).
- Picks one valid requester per cycle round-robin and registers its register number, data and write enable into a one-stage output buffer.
- The output register number feeds the existing 5-to-32 write-select decoder.
- Writes to register 0 are consumed but never asserted to the register file.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 86 ++++++++
 tb/tb_regfile_write_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package regfile_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int PTR_W    = 3;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) return '0;
        return idx + PTR_W'(1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotate requests by the pointer, take the
// lowest set bit, and map the winner back to its absolute requester index.
module rr_priority_picker
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_grant_any
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_double;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_rot_idx;
    logic [PTR_W:0]       w_sum;

    // NOTE: every output and temporary gets a default first so no latch is inferred.
    always_comb begin
        w_double    = {i_req_valid, i_req_valid};
        w_rot       = NUM_REQ'(w_double >> i_rr_ptr);
        w_rot_idx   = '0;
        o_grant_any = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rot_idx   = PTR_W'(i);
                o_grant_any = 1'b1;
            end
        end
        w_sum = {1'b0, w_rot_idx} + {1'b0, i_rr_ptr};
        if (w_sum >= N_EXT) w_sum = w_sum - N_EXT;
        o_grant_idx = w_sum[PTR_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = o_grant_any && (o_grant_idx == PTR_W'(i));
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port, with a
// one-stage registered output feeding the write-select decoder.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REG_W   = regfile_pkg::REG_W,
    parameter int DATA_W  = regfile_pkg::DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_W-1:0]  req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      ctrl_writeEnable,
    output logic [REG_W-1:0]          ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic [2:0]                last_grant_id
);

    import regfile_pkg::*;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_write_enable;
    logic [REG_W-1:0]   r_write_reg;
    logic [DATA_W-1:0]  r_write_data;
    logic [2:0]         r_last_grant_id;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_grant_any;
    logic [REG_W-1:0]   w_sel_reg;
    logic [DATA_W-1:0]  w_sel_data;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_pick_grant),
        .o_grant_idx (w_pick_idx),
        .o_grant_any (w_pick_any)
    );

    // Gating by reset here means no transfer can complete in a reset cycle.
    assign w_grant_any = w_pick_any & ~reset & ~stall;
    assign grant       = w_grant_any ? w_pick_grant : '0;

    always_comb begin
        w_sel_reg  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_grant[i]) begin
                w_sel_reg  = req_reg[i*REG_W +: REG_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr        <= '0;
            r_write_enable  <= 1'b0;
            r_write_reg     <= '0;
            r_write_data    <= '0;
            r_last_grant_id <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr        <= rr_next(w_pick_idx, NUM_REQ);
            r_write_enable  <= (w_sel_reg != REG_W'(ZERO_REG));
            r_write_reg     <= w_sel_reg;
            r_write_data    <= w_sel_data;
            r_last_grant_id <= w_pick_idx;
        end else begin
            r_write_enable  <= 1'b0;
        end
    end

    assign ctrl_writeEnable = r_write_enable;
    assign ctrl_writeReg    = r_write_reg;
    assign data_writeReg    = r_write_data;
    assign last_grant_id    = r_last_grant_id;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for multi-cycle
// corner cases, and randomized traffic against a round-robin reference model.
module tb_regfile_write_arbiter;

    localparam int N  = 4;
    localparam int RW = 5;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              stall;
    logic [N-1:0]      req_valid;
    logic [N*RW-1:0]   req_reg;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      grant;
    logic              ctrl_writeEnable;
    logic [RW-1:0]     ctrl_writeReg;
    logic [DW-1:0]     data_writeReg;
    logic [2:0]        last_grant_id;

    logic [RW-1:0]     rq_reg  [N];
    logic [DW-1:0]     rq_data [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_ptr;
    logic          m_we;
    logic [RW-1:0] m_reg;
    logic [DW-1:0] m_data;
    logic [2:0]    m_last;

    typedef struct {
        logic          rst;
        logic          stl;
        logic [N-1:0]  valid;
        logic [N-1:0]  exp_grant;
        logic          exp_we;
        logic [RW-1:0] exp_reg;
        logic [2:0]    exp_last;
    } vec_t;

    vec_t tbl [15];

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_reg[g*RW +: RW]  = rq_reg[g];
        assign req_data[g*DW +: DW] = rq_data[g];
    end

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .REG_W   (RW),
        .DATA_W  (DW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .req_valid        (req_valid),
        .req_reg          (req_reg),
        .req_data         (req_data),
        .grant            (grant),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .last_grant_id    (last_grant_id)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] g, input logic we,
                             input logic [RW-1:0] r, input logic [DW-1:0] d, input logic [2:0] last);
        check({tag, ".grant"}, 64'(grant), 64'(g));
        check({tag, ".we"},    64'(ctrl_writeEnable), 64'(we));
        check({tag, ".reg"},   64'(ctrl_writeReg), 64'(r));
        check({tag, ".data"},  64'(data_writeReg), 64'(d));
        check({tag, ".last"},  64'(last_grant_id), 64'(last));
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    // Scan from the pointer, wrapping, for the first valid requester.
    function automatic int model_pick();
        if (reset || stall) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input int pick);
        if (reset) begin
            m_ptr = 0; m_we = 1'b0; m_reg = '0; m_data = '0; m_last = '0;
        end else if (pick >= 0) begin
            m_ptr  = (pick + 1) % N;
            m_reg  = rq_reg[pick];
            m_data = rq_data[pick];
            m_last = 3'(pick);
            m_we   = (rq_reg[pick] != 0);
        end else begin
            m_we = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pick;
        int prev_pick;
        logic [N-1:0] exp_g;

        tbl[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 5'd0,  3'd0};
        tbl[1]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b0, 5'd0,  3'd0};
        tbl[2]  = '{1'b0, 1'b0, 4'b1111, 4'b0010, 1'b1, 5'd10, 3'd0};
        tbl[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1, 5'd11, 3'd1};
        tbl[4]  = '{1'b0, 1'b0, 4'b1111, 4'b1000, 1'b1, 5'd12, 3'd2};
        tbl[5]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 5'd13, 3'd3};
        tbl[6]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 5'd10, 3'd0};
        tbl[7]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd10, 3'd0};
        tbl[8]  = '{1'b0, 1'b1, 4'b0011, 4'b0000, 1'b0, 5'd10, 3'd0};
        tbl[9]  = '{1'b0, 1'b1, 4'b0011, 4'b0000, 1'b0, 5'd10, 3'd0};
        tbl[10] = '{1'b0, 1'b1, 4'b0011, 4'b0000, 1'b0, 5'd10, 3'd0};
        tbl[11] = '{1'b0, 1'b0, 4'b0011, 4'b0010, 1'b0, 5'd10, 3'd0};
        tbl[12] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 5'd11, 3'd1};
        tbl[13] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 5'd10, 3'd0};
        tbl[14] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 5'd10, 3'd0};

        for (int i = 0; i < N; i++) begin
            rq_reg[i]  = RW'(10 + i);
            rq_data[i] = 32'hA000_0000 + DW'(i);
        end
        reset = 1'b1; stall = 1'b0; req_valid = '0;
        advance();
        advance();

        // Directed table: reset, round-robin rotation, idle hold, stall.
        for (int v = 0; v < 15; v++) begin
            reset     = tbl[v].rst;
            stall     = tbl[v].stl;
            req_valid = tbl[v].valid;
            sample();
            check_all($sformatf("tbl%0d", v), tbl[v].exp_grant, tbl[v].exp_we, tbl[v].exp_reg,
                      (tbl[v].exp_reg == 0) ? 32'h0 : 32'hA000_0000 + DW'(tbl[v].exp_reg) - 32'd10,
                      tbl[v].exp_last);
            advance();
        end

        // Single requester 2 writes reg 17.
        rq_reg[2] = 5'd17; rq_data[2] = 32'hDEAD_BEEF; req_valid = 4'b0100;
        sample(); check_all("single.n",  4'b0100, 1'b0, 5'd10, 32'hA000_0000, 3'd0); advance();
        req_valid = 4'b0000;
        sample(); check_all("single.n1", 4'b0000, 1'b1, 5'd17, 32'hDEAD_BEEF, 3'd2); advance();
        sample(); check_all("single.n2", 4'b0000, 1'b0, 5'd17, 32'hDEAD_BEEF, 3'd2); advance();

        // Requester 1 writes reg 0: granted, pointer moves to 2, no write enable.
        rq_reg[1] = 5'd0; rq_data[1] = 32'h1234_5678; req_valid = 4'b0010;
        sample(); check_all("zero.n",  4'b0010, 1'b0, 5'd17, 32'hDEAD_BEEF, 3'd2); advance();
        rq_reg[2] = 5'd18; rq_data[2] = 32'h2222_2222;
        rq_reg[3] = 5'd19; rq_data[3] = 32'h3333_3333; req_valid = 4'b1110;
        sample(); check_all("zero.n1", 4'b0100, 1'b0, 5'd0, 32'h1234_5678, 3'd1); advance();
        req_valid = 4'b0000;
        sample(); check_all("zero.n2", 4'b0000, 1'b1, 5'd18, 32'h2222_2222, 3'd2); advance();

        // Requesters 0 and 3 both target reg 5 with pointer at 3.
        rq_reg[0] = 5'd5; rq_data[0] = 32'hAAAA_0000;
        rq_reg[3] = 5'd5; rq_data[3] = 32'hBBBB_0000; req_valid = 4'b1001;
        sample(); check_all("same.n",  4'b1000, 1'b0, 5'd18, 32'h2222_2222, 3'd2); advance();
        req_valid = 4'b0001;
        sample(); check_all("same.n1", 4'b0001, 1'b1, 5'd5, 32'hBBBB_0000, 3'd3); advance();
        req_valid = 4'b0000;
        sample(); check_all("same.n2", 4'b0000, 1'b1, 5'd5, 32'hAAAA_0000, 3'd0); advance();

        // Streams on requesters 1 and 2 with reset asserted mid-stream.
        rq_reg[1] = 5'd7; rq_data[1] = 32'h7777_0001;
        rq_reg[2] = 5'd8; rq_data[2] = 32'h8888_0002; req_valid = 4'b0110;
        sample(); check_all("mrst.s1", 4'b0010, 1'b0, 5'd5, 32'hAAAA_0000, 3'd0); advance();
        sample(); check_all("mrst.s2", 4'b0100, 1'b1, 5'd7, 32'h7777_0001, 3'd1); advance();
        sample(); check_all("mrst.s3", 4'b0010, 1'b1, 5'd8, 32'h8888_0002, 3'd2); advance();
        reset = 1'b1;
        sample(); check_all("mrst.r",  4'b0000, 1'b1, 5'd7, 32'h7777_0001, 3'd1); advance();
        reset = 1'b0;
        sample(); check_all("mrst.a1", 4'b0010, 1'b0, 5'd0, 32'h0, 3'd0); advance();
        req_valid = 4'b0000;
        sample(); check_all("mrst.a2", 4'b0000, 1'b1, 5'd7, 32'h7777_0001, 3'd1); advance();

        // Randomized traffic against the reference model.
        reset = 1'b1; stall = 1'b0; req_valid = '0;
        advance();
        model_edge(-1);
        reset = 1'b0;
        prev_pick = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && prev_pick != i) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    if (req_valid[i]) begin
                        rq_reg[i]  = ($urandom_range(0, 5) == 0) ? 5'd0 : RW'($urandom);
                        rq_data[i] = $urandom;
                    end
                end
            end
            stall = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            sample();
            pick  = model_pick();
            exp_g = (pick >= 0) ? N'(1 << pick) : '0;
            check_all($sformatf("rnd%0d", cyc), exp_g, m_we, m_reg, m_data, m_last);
            model_edge(pick);
            prev_pick = pick;
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
